dm_cache_ctrl: RTL and testbench

Controller FSM for the direct-mapped, write-back data cache: sequences the 16-entry tag store and the data line store, and moves whole lines to and from main memory. Sits between the pipeline MEM stage (CPU side) and the memory interface. Issues a tag/data request (index, we) per cycle. Handles hit, clean-miss allocate and dirty-miss write-back. Sweeps the tag store invalid after reset.

---
 rtl/dm_cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Controller for a direct-mapped, write-back data cache: sweeps the tag store
// after reset, serves hits, and moves whole lines to and from main memory.
module dm_cache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 4,
    parameter int LINE_W  = 128,
    parameter int TAG_W   = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_valid,
    input  logic                cpu_rw,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic                cpu_ready,
    output logic [31:0]         cpu_rdata,
    output logic                mem_valid,
    output logic                mem_rw,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [LINE_W-1:0]   mem_rdata,
    output logic [INDEX_W-1:0]  tag_index,
    output logic                tag_we,
    output logic [TAG_W+1:0]    tag_wdata,
    input  logic [TAG_W+1:0]    tag_rdata,
    output logic [INDEX_W-1:0]  data_index,
    output logic                data_we,
    output logic [LINE_W-1:0]   data_wdata,
    input  logic [LINE_W-1:0]   data_rdata
);

    localparam int OFF_W = ADDR_W - INDEX_W - TAG_W;

    typedef enum logic [2:0] {INIT, IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t              state, next_state;
    logic [INDEX_W-1:0]  init_cnt;
    logic                req_rw;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         req_wdata;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [1:0]          word_sel;
    logic [6:0]          word_base;
    logic                stored_valid, stored_dirty, hit;
    logic [TAG_W-1:0]    stored_tag;
    logic [LINE_W-1:0]   merged_line;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            init_cnt  <= '0;
            req_rw    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            state <= next_state;
            if (state == INIT)
                init_cnt <= init_cnt + 1'b1;
            if (state == IDLE && cpu_valid) begin
                req_rw    <= cpu_rw;
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
            end
        end
    end

    assign req_tag      = req_addr[ADDR_W-1 -: TAG_W];
    assign req_index    = req_addr[OFF_W +: INDEX_W];
    assign word_sel     = req_addr[3:2];
    assign word_base    = {word_sel, 5'b0};
    assign stored_valid = tag_rdata[TAG_W+1];
    assign stored_dirty = tag_rdata[TAG_W];
    assign stored_tag   = tag_rdata[TAG_W-1:0];
    assign hit          = stored_valid && (stored_tag == req_tag);
    assign data_index   = tag_index;

    always_comb begin
        merged_line = data_rdata;
        merged_line[word_base +: 32] = req_wdata;
    end

    // Every strobe is forced low while reset is held so nothing escapes mid-reset.
    always_comb begin
        next_state = state;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        mem_valid  = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        tag_index  = req_index;
        tag_we     = 1'b0;
        tag_wdata  = '0;
        data_we    = 1'b0;
        data_wdata = '0;
        if (reset) begin
            case (state)
                INIT: begin
                    tag_index = init_cnt;
                    tag_we    = 1'b1;
                    if (init_cnt == {INDEX_W{1'b1}})
                        next_state = IDLE;
                end
                IDLE: begin
                    if (cpu_valid)
                        next_state = COMPARE;
                end
                COMPARE: begin
                    if (hit) begin
                        cpu_ready  = 1'b1;
                        next_state = IDLE;
                        if (req_rw) begin
                            data_we    = 1'b1;
                            data_wdata = merged_line;
                            tag_we     = 1'b1;
                            tag_wdata  = {1'b1, 1'b1, req_tag};
                        end else begin
                            cpu_rdata = data_rdata[word_base +: 32];
                        end
                    end else if (stored_valid && stored_dirty) begin
                        next_state = WRITE_BACK;
                    end else begin
                        next_state = ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    mem_valid = 1'b1;
                    mem_rw    = 1'b1;
                    mem_addr  = {stored_tag, req_index, {OFF_W{1'b0}}};
                    mem_wdata = data_rdata;
                    if (mem_ready)
                        next_state = ALLOCATE;
                end
                ALLOCATE: begin
                    mem_valid = 1'b1;
                    mem_addr  = {req_tag, req_index, {OFF_W{1'b0}}};
                    if (mem_ready) begin
                        data_we    = 1'b1;
                        data_wdata = mem_rdata;
                        tag_we     = 1'b1;
                        tag_wdata  = {1'b1, 1'b0, req_tag};
                        next_state = COMPARE;
                    end
                end
                default: next_state = INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with behavioural tag/data stores and a
// line-granular main memory whose response delay is set per step.
module tb_dm_cache_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_valid, cpu_rw;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         mem_valid, mem_rw, mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [3:0]   tag_index, data_index;
    logic         tag_we, data_we;
    logic [25:0]  tag_wdata, tag_rdata;
    logic [127:0] data_wdata, data_rdata;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .tag_index(tag_index), .tag_we(tag_we), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
        .data_index(data_index), .data_we(data_we), .data_wdata(data_wdata), .data_rdata(data_rdata)
    );

    logic [25:0]  tag_mem  [0:15];
    logic [127:0] data_mem [0:15];

    assign tag_rdata  = tag_mem[tag_index];
    assign data_rdata = data_mem[data_index];

    always @(posedge clk) begin
        if (tag_we)  tag_mem[tag_index]   <= tag_wdata;
        if (data_we) data_mem[data_index] <= data_wdata;
    end

    // Main memory: fixed contents per line address, ready after mem_delay extra cycles.
    int mem_delay = 0;
    int wait_cnt  = 0;

    function automatic logic [127:0] fill_line(input logic [31:0] a);
        if (a == 32'h0000_0120)
            return 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        return {a ^ 32'h3333_0000, a ^ 32'h2222_0000, a ^ 32'h1111_0000, a ^ 32'hF00D_0000};
    endfunction

    assign mem_ready = mem_valid && (wait_cnt == mem_delay);
    assign mem_rdata = fill_line(mem_addr);

    always @(posedge clk) begin
        if (!mem_valid || mem_ready) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    typedef struct {
        logic        rw;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } mreq_t;

    exp_t         sb_q[$];
    mreq_t        mem_log[$];
    int           checks = 0;
    int           errors = 0;
    int           unstable = 0;
    int           cyc;
    logic [3:0]   last_tag_index;
    logic [25:0]  last_tag_wdata;
    logic [127:0] last_data_wdata;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_access(input logic rw, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata);
        exp_t e;
        e.rw    = rw;
        e.rdata = exp_rdata;
        sb_q.push_back(e);
        mem_log.delete();
        last_tag_index  = '0;
        last_tag_wdata  = '0;
        last_data_wdata = '0;
        cpu_valid = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic init_sweep();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("init_%0d", i), {tag_we, tag_index, data_index, tag_wdata},
                  {1'b1, i[3:0], i[3:0], 26'd0});
        end
        @(negedge clk);
        check("init_done", {tag_we, cpu_ready, mem_valid}, 3'b000);
    endtask

    // Runs cycles until cpu_ready, logging memory handshakes and store writes.
    task automatic wait_ready(input int budget, output int cycles);
        logic  got;
        logic  prev_open;
        mreq_t prev;
        mreq_t cur;
        exp_t  e;
        got       = 1'b0;
        prev_open = 1'b0;
        cycles    = 0;
        while (!got && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (mem_valid) begin
                cur = '{mem_rw, mem_addr, mem_wdata};
                if (prev_open && ({cur.rw, cur.addr, cur.wdata} !== {prev.rw, prev.addr, prev.wdata}))
                    unstable++;
                prev      = cur;
                prev_open = !mem_ready;
                if (mem_ready) mem_log.push_back(cur);
            end else begin
                prev_open = 1'b0;
            end
            if (tag_we) begin
                last_tag_index = tag_index;
                last_tag_wdata = tag_wdata;
            end
            if (data_we) last_data_wdata = data_wdata;
            if (cpu_ready) begin
                got = 1'b1;
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    if (!e.rw) check("rdata", cpu_rdata, e.rdata);
                end
            end
        end
        check("ready_seen", got, 1'b1);
        @(posedge clk);
        #1 cpu_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        cpu_valid = 1'b0;
        cpu_rw    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;

        #12;
        check("rst_strobes", {cpu_ready, mem_valid, tag_we, data_we}, 4'b0000);
        check("rst_outs", {cpu_rdata, mem_addr}, 64'd0);

        // Read miss on an empty cache, requested while the sweep is still running.
        @(posedge clk);
        #1 reset = 1'b1;
        mem_delay = 2;
        start_access(1'b0, 32'h0000_0124, 32'h0, 32'h2222_2222);
        init_sweep();
        wait_ready(40, cyc);
        check("a1_latency", cyc + 1, 6);
        check("a1_mem_count", mem_log.size(), 1);
        check("a1_mem_req", {mem_log[0].rw, mem_log[0].addr}, {1'b0, 32'h0000_0120});
        check("a1_tag_write", {last_tag_index, last_tag_wdata}, {4'd2, 2'b10, 24'h000001});

        @(negedge clk);
        check("idle_rdata", {cpu_ready, cpu_rdata}, 33'd0);
        @(posedge clk);
        #1;

        // Write hit on the freshly filled line.
        start_access(1'b1, 32'h0000_0128, 32'hDEAD_BEEF, 32'h0);
        wait_ready(10, cyc);
        check("a2_latency", cyc, 2);
        check("a2_no_mem", mem_log.size(), 0);
        check("a2_data_write", last_data_wdata, 128'h4444_4444_DEAD_BEEF_2222_2222_1111_1111);
        check("a2_tag_write", {last_tag_index, last_tag_wdata}, {4'd2, 2'b11, 24'h000001});

        // Conflicting read forces a write-back of the dirty line, then a fill.
        mem_delay = 1;
        start_access(1'b0, 32'h0000_0220, 32'h0, 32'hF00D_0220);
        wait_ready(40, cyc);
        check("a3_latency", cyc, 7);
        check("a3_mem_count", mem_log.size(), 2);
        check("a3_write_back", {mem_log[0].rw, mem_log[0].addr, mem_log[0].wdata},
              {1'b1, 32'h0000_0120, 128'h4444_4444_DEAD_BEEF_2222_2222_1111_1111});
        check("a3_fill", {mem_log[1].rw, mem_log[1].addr}, {1'b0, 32'h0000_0220});
        check("a3_tag_write", {last_tag_index, last_tag_wdata}, {4'd2, 2'b10, 24'h000002});

        // Slow memory: request must hold steady for the whole stall.
        mem_delay = 10;
        unstable  = 0;
        start_access(1'b0, 32'h0000_0344, 32'h0, 32'h1111_0340);
        wait_ready(40, cyc);
        check("a4_latency", cyc, 14);
        check("a4_stable", unstable, 0);
        check("a4_mem_count", mem_log.size(), 1);
        check("a4_fill", {mem_log[0].rw, mem_log[0].addr}, {1'b0, 32'h0000_0340});
        check("a4_tag_write", {last_tag_index, last_tag_wdata}, {4'd4, 2'b10, 24'h000003});

        // Reset in the middle of a fill abandons it and reruns the sweep.
        mem_delay = 50;
        start_access(1'b0, 32'h0000_0560, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("a5_alloc", {mem_valid, mem_rw, mem_addr}, {1'b1, 1'b0, 32'h0000_0560});
        #2 reset = 1'b0;
        #1;
        check("a5_reset_drop", {mem_valid, cpu_ready, tag_we, data_we}, 4'b0000);
        sb_q.delete();
        cpu_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        mem_delay = 0;
        start_access(1'b0, 32'h0000_0124, 32'h0, 32'h2222_2222);
        init_sweep();
        wait_ready(40, cyc);
        check("a6_latency", cyc + 1, 4);
        check("a6_mem_count", mem_log.size(), 1);
        check("a6_fill", {mem_log[0].rw, mem_log[0].addr}, {1'b0, 32'h0000_0120});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
